// File: rtl/maxplus_pkg.sv
// rtl/maxplus_pkg.sv - shared word type, widths and deserializer states
package maxplus_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = $clog2(WORD_W) + 1;

    // Word type shared with the extractor's 16-bit input.
    typedef logic [WORD_W-1:0] word_t;

    // COLLECT: shifting bits in (pend = 0).
    // HOLD:    shift register holds a complete word waiting for the output slot (pend = 1).
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/deserializer16.sv
// rtl/deserializer16.sv - serial bit stream to 16-bit word deserializer with one-word slack
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - synchronous flush of partial and pending words
//   bit_in       - serial data bit, qualified by bit_valid, accepted when bit_ready
//   word_out     - registered assembled word, qualified by word_valid, consumed on word_ready
//   bit_count    - bits collected in the current partial word
module deserializer16
    import maxplus_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [4:0]       bit_count
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               last;
    logic               slot_free;
    logic [CNT_W-1:0]   pos;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   assembled;

    assign bit_ready = (state_q == ST_COLLECT);
    assign accept    = bit_valid && bit_ready;
    assign last      = accept && (cnt_q == CNT_W'(WIDTH - 1));
    assign slot_free = !valid_q || word_ready;

    // Write position for the incoming bit; a shifted one-hot mask avoids
    // indexing the word with a wider-than-needed counter.
    assign pos       = MSB_FIRST ? (CNT_W'(WIDTH - 1) - cnt_q) : cnt_q;
    assign mask      = {{(WIDTH-1){1'b0}}, 1'b1} << pos;
    assign assembled = bit_in ? (shreg_q | mask) : (shreg_q & ~mask);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;

        if (clear) begin
            // word_out keeps its value; only the handshake and partial state are dropped.
            state_d = ST_COLLECT;
            shreg_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (accept) begin
                shreg_d = assembled;
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            end

            if (state_q == ST_HOLD) begin
                // No bit is accepted in HOLD, so shreg_q is the complete pending word.
                if (slot_free) begin
                    word_d  = shreg_q;
                    valid_d = 1'b1;
                    state_d = ST_COLLECT;
                end
            end else if (last) begin
                if (slot_free) begin
                    // Bypass the shift register so the word appears one edge after its last bit.
                    word_d  = assembled;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end else if (valid_q && word_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            shreg_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign bit_count  = 5'(cnt_q);

endmodule

// File: tb/tb_deserializer16.sv
// tb/tb_deserializer16.sv - scoreboard bench for deserializer16 (LSB-first and MSB-first instances)
module tb_deserializer16;
    import maxplus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       bit_in;
    logic       bv_l, bv_m;
    logic       word_ready;
    logic       br_l, br_m;
    word_t      wo_l, wo_m;
    logic       wv_l, wv_m;
    logic [4:0] bc_l, bc_m;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    word_t exp_l[$];
    word_t exp_m[$];
    int    pop_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    deserializer16 #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
        .bit_valid(bv_l), .bit_ready(br_l), .word_out(wo_l),
        .word_valid(wv_l), .word_ready(word_ready), .bit_count(bc_l)
    );

    deserializer16 #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
        .bit_valid(bv_m), .bit_ready(br_m), .word_out(wo_m),
        .word_valid(wv_m), .word_ready(word_ready), .bit_count(bc_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a word is handed off downstream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wv_l && word_ready) begin
                vectors++;
                if (exp_l.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word_lsb: got %h expected none", wo_l);
                end else begin
                    automatic word_t e = exp_l.pop_front();
                    if (wo_l !== e) begin
                        miscompares++;
                        $display("FAIL word_lsb: got %h expected %h", wo_l, e);
                    end
                    pop_times.push_back(cyc);
                end
            end
            if (wv_m && word_ready) begin
                vectors++;
                if (exp_m.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word_msb: got %h expected none", wo_m);
                end else begin
                    automatic word_t e = exp_m.pop_front();
                    if (wo_m !== e) begin
                        miscompares++;
                        $display("FAIL word_msb: got %h expected %h", wo_m, e);
                    end
                end
            end
        end
    end

    // Present one bit and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic send_bit(input logic b, input bit to_m);
        bit_in = b;
        if (to_m) bv_m = 1'b1; else bv_l = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (to_m ? br_m : br_l) begin
                @(posedge clk);
                #1;
                bit_in = 1'b0;
                bv_l   = 1'b0;
                bv_m   = 1'b0;
                return;
            end
        end
        check("send_bit_timeout", 32'd0, 32'd1);
        bv_l = 1'b0;
        bv_m = 1'b0;
    endtask

    task automatic send_word_lsb(input word_t w);
        for (int i = 0; i < 16; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic send_seq(input logic [0:15] s, input bit to_m);
        for (int i = 0; i < 16; i++) send_bit(s[i], to_m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] seq_l;
        logic [0:15] seq_m;
        word_t       words [4];
        word_t       wy;
        seq_l = 16'b1100_0011_1010_0101;
        seq_m = 16'b1010_0101_1100_0011;
        words[0] = 16'h0F0F; words[1] = 16'h8001; words[2] = 16'hFFFF; words[3] = 16'h1357;

        rst_n = 1'b0; clear = 1'b0; bit_in = 1'b0; bv_l = 1'b0; bv_m = 1'b0; word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_bit_ready", br_l, 1);
        check("rst_word_valid", wv_l, 0);
        check("rst_word_out", wo_l, 16'h0000);
        check("rst_bit_count", bc_l, 0);
        check("rst_bit_ready_msb", br_m, 1);

        // Async reset mid-hold and mid-word: nothing may be emitted afterwards.
        word_ready = 1'b0;
        send_word_lsb(16'hFFFF);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("pre_rst_count", bc_l, 5);
        check("pre_rst_valid", wv_l, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", wv_l, 0);
        check("async_rst_word", wo_l, 16'h0000);
        check("async_rst_count", bc_l, 0);
        check("async_rst_ready", br_l, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        word_ready = 1'b1;

        // LSB-first assembly, one-cycle latency, one-cycle pulse.
        exp_l.push_back(16'hA5C3);
        send_seq(seq_l, 1'b0);
        check("lsb_latency_valid", wv_l, 1);
        check("lsb_word", wo_l, 16'hA5C3);
        @(posedge clk); #1;
        check("lsb_pulse_end", wv_l, 0);

        // Back-pressure: second word parks in the shift register.
        word_ready = 1'b0;
        exp_l.push_back(16'h1234);
        exp_l.push_back(16'hBEEF);
        send_word_lsb(16'h1234);
        check("bp_first_valid", wv_l, 1);
        check("bp_first_word", wo_l, 16'h1234);
        send_word_lsb(16'hBEEF);
        check("bp_hold_ready", br_l, 0);
        check("bp_hold_word", wo_l, 16'h1234);
        @(posedge clk); #1;
        check("bp_hold_stable_word", wo_l, 16'h1234);
        check("bp_hold_stable_valid", wv_l, 1);
        word_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_refill_word", wo_l, 16'hBEEF);
        check("bp_refill_valid", wv_l, 1);
        check("bp_refill_ready", br_l, 1);
        @(posedge clk); #1;
        check("bp_drained", wv_l, 0);

        // Consume and completion in the same cycle.
        word_ready = 1'b0;
        exp_l.push_back(16'h00FF);
        exp_l.push_back(16'hC001);
        send_word_lsb(16'h00FF);
        wy = 16'hC001;
        for (int i = 0; i < 15; i++) send_bit(wy[i], 1'b0);
        word_ready = 1'b1;
        send_bit(wy[15], 1'b0);
        check("swap_valid", wv_l, 1);
        check("swap_word", wo_l, 16'hC001);
        @(posedge clk); #1;

        // Continuous stream: 64 bits, no stall, 16-cycle word spacing.
        pop_times.delete();
        for (int w = 0; w < 4; w++) exp_l.push_back(words[w]);
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 16; i++) begin
                bit_in = words[w][i];
                bv_l   = 1'b1;
                @(negedge clk);
                check("stream_bit_ready", br_l, 1);
                @(posedge clk); #1;
            end
        end
        bv_l = 1'b0;
        @(posedge clk); #1;
        check("stream_words", pop_times.size(), 4);
        if (pop_times.size() == 4)
            for (int k = 1; k < 4; k++)
                check("stream_spacing", pop_times[k] - pop_times[k-1], 16);

        // Clear mid-word with a bit presented in the same cycle.
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        check("clr_pre_count", bc_l, 7);
        bit_in = 1'b1; bv_l = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; bv_l = 1'b0; bit_in = 1'b0;
        check("clr_count", bc_l, 0);
        check("clr_valid", wv_l, 0);
        exp_l.push_back(16'h4200);
        send_word_lsb(16'h4200);
        check("clr_clean_word", wo_l, 16'h4200);
        @(posedge clk); #1;

        // MSB-first assembly.
        exp_m.push_back(16'hA5C3);
        send_seq(seq_m, 1'b1);
        check("msb_latency_valid", wv_m, 1);
        check("msb_word", wo_m, 16'hA5C3);
        @(posedge clk); #1;
        check("msb_pulse_end", wv_m, 0);

        repeat (2) @(posedge clk);
        #1;
        check("lsb_queue_empty", exp_l.size(), 0);
        check("msb_queue_empty", exp_m.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer16.md
Name: deserializer16

Overview:
- Upstream feeder for the 16-wire extractor stage.
- Collects a serial bit stream under a valid/ready handshake and assembles it into 16-bit words.
- Presents each word on a registered parallel bus with its own valid/ready handshake; that bus drives the extractor's 16-bit input directly.
- One-word slack (shift register plus output register) gives full bit-rate throughput under light back-pressure.

Parameters:
- WIDTH, 16, word width in bits. Must be 16 to mate with the extractor; the parameter exists for verification only.
- MSB_FIRST, 0:
  - 0: the first received bit lands in word bit 0.
  - 1: the first received bit lands in word bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: drops any partial or pending word.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- word_out  output  WIDTH  assembled word; feeds the extractor's "in".
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream consumes word_out this cycle.
- bit_count  output  5  bits collected in the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shift register = 0, cnt = 0, pend = 0.
  - word_out = 0, word_valid = 0.
  - bit_ready = 1 and bit_count = 0 on the first cycle after release.
- bit_ready = !pend (combinational). bit_count = cnt (registered).
- Bit accept: bit_valid && bit_ready.
  - MSB_FIRST=0: the bit is written at position cnt.
  - MSB_FIRST=1: the bit is written at position WIDTH-1-cnt.
  - cnt increments on accept.
- slot_free = !word_valid || word_ready.
- Word completion: accept with cnt==WIDTH-1.
  - cnt <= 0.
  - If slot_free: word_out <= assembled word including this bit; word_valid <= 1.
  - Else: the shift register holds the complete word and pend <= 1.
- Pending transfer: if pend && slot_free, then word_out <= shift register, word_valid <= 1, pend <= 0.
  - No bit can be accepted in that cycle, because bit_ready = 0 while pend = 1.
- Consume without refill: word_valid && word_ready with no transfer in that cycle gives word_valid <= 0. word_out keeps its last value.
- Latency: word_valid rises on the edge after the 16th bit is accepted (1 cycle).
- Throughput: one bit per cycle sustained indefinitely while word_ready is held at 1.
- word_out and word_valid are stable while word_valid=1 && word_ready=0 (standard handshake hold).
- States: COLLECT (pend=0) and HOLD (pend=1).
  - COLLECT -> HOLD on word completion with !slot_free.
  - HOLD -> COLLECT on slot_free.
- Simultaneous events:
  - Consume and completion in the same cycle: the new word replaces the old one; word_valid stays 1.
  - clear has priority over every event: cnt, pend and word_valid <= 0; a bit presented in that cycle is discarded; word_out is left unchanged.
- Reset mid-word or mid-hold: all state is lost immediately; no partial word is ever emitted.
- Bits are never dropped or duplicated outside clear and reset.

Decomposition:
- Shared package maxplus_pkg:
  - WORD_W = 16.
  - CNT_W = $clog2(WORD_W) + 1.
  - Typedef word_t = logic [WORD_W-1:0], shared with the extractor's input.
- No sub-module. The shift register plus output slot stays in one module of about 150 lines.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-cycle -> all outputs drop immediately; after release, bit_ready=1, word_valid=0, word_out=16'h0000, bit_count=0.
- LSB-first assembly: MSB_FIRST=0, word_ready=1, bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles -> word_out=16'hA5C3 with word_valid=1 exactly one cycle after the 16th bit; a one-cycle word_valid pulse.
- Back-pressure: word_ready=0, stream 32 bits carrying 16'h1234 then 16'hBEEF ->
  - word_out=16'h1234, valid.
  - bit_ready=0 after the 32nd bit is accepted.
  - Raise word_ready -> 16'hBEEF appears the next cycle, bit_ready=1 again, 16'h1234 is consumed exactly once.
- Continuous stream: word_ready=1, 64 back-to-back bits with bit_valid=1 -> 4 words at 16-cycle spacing; bit_ready never drops.
- Clear mid-word: 7 bits, then clear=1 together with bit_valid=1 -> bit_count=0, word_valid=0; the next 16 bits form a clean word with no leftover bits.
- MSB-first assembly: MSB_FIRST=1, bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 -> word_out=16'hA5C3.
